// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: output modes, 3x3 window tap indices and magnitude width derivation.
// Also used by the window generator and the testbench.
package sobel_pkg;

   localparam logic [1:0] MODE_L1     = 2'd0;
   localparam logic [1:0] MODE_LEGACY = 2'd1;
   localparam logic [1:0] MODE_BIN    = 2'd2;
   localparam logic [1:0] MODE_MAX    = 2'd3;

   // Row-major window taps, d0 = top-left.
   localparam int WIN_D0 = 0;
   localparam int WIN_D1 = 1;
   localparam int WIN_D2 = 2;
   localparam int WIN_D3 = 3;
   localparam int WIN_D4 = 4;
   localparam int WIN_D5 = 5;
   localparam int WIN_D6 = 6;
   localparam int WIN_D7 = 7;
   localparam int WIN_D8 = 8;

   // |gx|+|gy| <= 8*(2^pix_w-1) needs three extra bits.
   function automatic int mag_w(input int pix_w);
      return pix_w + 3;
   endfunction

endpackage

// File: rtl/sobel_grad_pipe_if.sv
// Window-in / pixel-out stream bundle of the Sobel engine; master is the upstream/downstream side,
// slave is the engine.
interface sobel_grad_pipe_if #(
   parameter int PIX_W = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [9*PIX_W-1:0] in_win;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [PIX_W-1:0]   out_pix;
   logic               out_edge;
   logic               out_last;

   modport master (
      output in_valid, in_win, in_last, out_ready,
      input  in_ready, out_valid, out_pix, out_edge, out_last
   );

   modport slave (
      input  in_valid, in_win, in_last, out_ready,
      output in_ready, out_valid, out_pix, out_edge, out_last
   );
endinterface

// File: rtl/sobel_abs_diff.sv
// Registered absolute difference |a-b| with clock enable; one instance per gradient axis.
module sobel_abs_diff #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   always_ff @(posedge clk) begin
      if (rst) begin
         y <= '0;
      end else if (en) begin
         y <= (a >= b) ? (a - b) : (b - a);
      end
   end

endmodule

// File: rtl/sobel_grad_pipe.sv
// Stallable 4-stage Sobel gradient engine: partial sums, |gx|/|gy|, magnitude/max, mode select.
// Also keeps a per-frame count of edge pixels reported at each frame end.
module sobel_grad_pipe
   import sobel_pkg::*;
#(
   parameter int  PIX_W = 8,
   parameter int  CNT_W = 20,
   localparam int MAG_W = mag_w(PIX_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cfg_mode,
   input  logic [MAG_W-1:0] cfg_thresh,
   sobel_grad_pipe_if.slave bus,
   output logic [CNT_W-1:0] edge_count,
   output logic             count_valid
);

   localparam logic [MAG_W-1:0] PMAX_MAG = MAG_W'((1 << PIX_W) - 1);
   localparam logic [PIX_W-1:0] PMAX_PIX = {PIX_W{1'b1}};

   logic en;
   assign en           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = en;

   logic [MAG_W-1:0] d [9];
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
         assign d[gi] = MAG_W'(bus.in_win[gi*PIX_W +: PIX_W]);
      end
   endgenerate

   logic unused_center;
   assign unused_center = ^d[WIN_D4];

   // Sideband (valid, mode, threshold, last) travels alongside the data of stages 1..3.
   logic             valid_reg [1:3];
   logic [1:0]       mode_reg  [1:3];
   logic [MAG_W-1:0] thr_reg   [1:3];
   logic             last_reg  [1:3];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 1; s <= 3; s++) begin
            valid_reg[s] <= 1'b0;
            mode_reg[s]  <= '0;
            thr_reg[s]   <= '0;
            last_reg[s]  <= 1'b0;
         end
      end else if (en) begin
         valid_reg[1] <= bus.in_valid;
         mode_reg[1]  <= cfg_mode;
         thr_reg[1]   <= cfg_thresh;
         last_reg[1]  <= bus.in_last;
         for (int s = 2; s <= 3; s++) begin
            valid_reg[s] <= valid_reg[s-1];
            mode_reg[s]  <= mode_reg[s-1];
            thr_reg[s]   <= thr_reg[s-1];
            last_reg[s]  <= last_reg[s-1];
         end
      end
   end

   // S1: left, right, top, bottom column/row weighted sums.
   logic [MAG_W-1:0] sum_reg [4];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) sum_reg[k] <= '0;
      end else if (en) begin
         sum_reg[0] <= d[WIN_D0] + (d[WIN_D3] << 1) + d[WIN_D6];
         sum_reg[1] <= d[WIN_D2] + (d[WIN_D5] << 1) + d[WIN_D8];
         sum_reg[2] <= d[WIN_D0] + (d[WIN_D1] << 1) + d[WIN_D2];
         sum_reg[3] <= d[WIN_D6] + (d[WIN_D7] << 1) + d[WIN_D8];
      end
   end

   // S2: abs_reg[0] = |gx|, abs_reg[1] = |gy|.
   logic [MAG_W-1:0] abs_reg [2];
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_abs
         sobel_abs_diff #(.W(MAG_W)) u_abs (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .a   (sum_reg[2*gi]),
            .b   (sum_reg[2*gi+1]),
            .y   (abs_reg[gi])
         );
      end
   endgenerate

   // S3: L1 magnitude and dominant axis.
   logic [MAG_W-1:0] mag_reg;
   logic [MAG_W-1:0] max_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         mag_reg <= '0;
         max_reg <= '0;
      end else if (en) begin
         mag_reg <= abs_reg[0] + abs_reg[1];
         max_reg <= (abs_reg[0] >= abs_reg[1]) ? abs_reg[0] : abs_reg[1];
      end
   end

   // S4: threshold and output mode select.
   logic             edge_flag;
   logic [PIX_W-1:0] clip_mag;
   logic [PIX_W-1:0] clip_max;
   logic [PIX_W-1:0] pix_next;

   assign edge_flag = (mag_reg >= thr_reg[3]);
   assign clip_mag  = (mag_reg > PMAX_MAG) ? PMAX_PIX : mag_reg[PIX_W-1:0];
   assign clip_max  = (max_reg > PMAX_MAG) ? PMAX_PIX : max_reg[PIX_W-1:0];

   always_comb begin
      pix_next = clip_mag;
      case (mode_reg[3])
         MODE_L1:     pix_next = clip_mag;
         MODE_LEGACY: pix_next = edge_flag ? PMAX_PIX : clip_mag;
         MODE_BIN:    pix_next = edge_flag ? PMAX_PIX : '0;
         MODE_MAX:    pix_next = clip_max;
         default:     pix_next = clip_mag;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_pix   <= '0;
         bus.out_edge  <= 1'b0;
         bus.out_last  <= 1'b0;
      end else if (en) begin
         bus.out_valid <= valid_reg[3];
         bus.out_pix   <= pix_next;
         bus.out_edge  <= edge_flag;
         bus.out_last  <= last_reg[3];
      end
   end

   // The frame-closing pixel is included in the reported count; counting then restarts at zero.
   logic             out_hs;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   assign out_hs   = bus.out_valid && bus.out_ready;
   assign cnt_next = (bus.out_edge && (cnt_reg != '1)) ? cnt_reg + CNT_W'(1) : cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= '0;
         edge_count  <= '0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         if (out_hs) begin
            if (bus.out_last) begin
               edge_count  <= cnt_next;
               count_valid <= 1'b1;
               cnt_reg     <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Scoreboard bench for sobel_grad_pipe: expectations queued at input handshake, compared at output handshake.
module tb_sobel_grad_pipe;
   import sobel_pkg::*;

   localparam int PIX_W = 8;
   localparam int CNT_W = 20;
   localparam int MAG_W = mag_w(PIX_W);

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       cfg_mode;
   logic [MAG_W-1:0] cfg_thresh;
   logic [CNT_W-1:0] edge_count;
   logic             count_valid;

   always #5 clk = ~clk;

   sobel_grad_pipe_if #(.PIX_W(PIX_W)) bus ();

   sobel_grad_pipe #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_mode    (cfg_mode),
      .cfg_thresh  (cfg_thresh),
      .bus         (bus),
      .edge_count  (edge_count),
      .count_valid (count_valid)
   );

   typedef struct {
      int pix;
      int edge_bit;
      int last;
   } exp_t;

   exp_t sb_q[$];
   int   cnt_q[$];
   int   model_cnt  = 0;
   int   cv_pulses  = 0;
   int   lasts_sent = 0;
   int   checks     = 0;
   int   failures   = 0;
   int   px[9];
   exp_t mon_e;
   logic [PIX_W-1:0] held_pix;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [9*PIX_W-1:0] pack_px();
      logic [9*PIX_W-1:0] w;
      for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'(px[k]);
      return w;
   endfunction

   function automatic exp_t model(input logic [9*PIX_W-1:0] w, input int mode, input int thr, input int last);
      int   dv[9];
      int   gx, gy, ax, ay, mag, mx, clip, pmax;
      exp_t e;
      pmax = (1 << PIX_W) - 1;
      for (int k = 0; k < 9; k++) dv[k] = int'(w[k*PIX_W +: PIX_W]);
      gx   = (dv[0] + 2*dv[3] + dv[6]) - (dv[2] + 2*dv[5] + dv[8]);
      gy   = (dv[0] + 2*dv[1] + dv[2]) - (dv[6] + 2*dv[7] + dv[8]);
      ax   = (gx < 0) ? -gx : gx;
      ay   = (gy < 0) ? -gy : gy;
      mag  = ax + ay;
      mx   = (ax > ay) ? ax : ay;
      e.edge_bit = (mag >= thr) ? 1 : 0;
      clip = (mag > pmax) ? pmax : mag;
      case (mode)
         0:       e.pix = clip;
         1:       e.pix = e.edge_bit ? pmax : clip;
         2:       e.pix = e.edge_bit ? pmax : 0;
         default: e.pix = (mx > pmax) ? pmax : mx;
      endcase
      e.last = last;
      return e;
   endfunction

   // use_exp selects hand-derived constants instead of the arithmetic model.
   task automatic send(input logic [9*PIX_W-1:0] w, input int mode, input int thr, input int last,
                       input bit use_exp, input int ep, input int ee);
      exp_t e;
      int   guard = 0;
      e = model(w, mode, thr, last);
      if (use_exp) begin
         e.pix      = ep;
         e.edge_bit = ee;
      end
      bus.in_valid = 1'b1;
      bus.in_win   = w;
      bus.in_last  = last[0];
      cfg_mode     = mode[1:0];
      cfg_thresh   = MAG_W'(thr);
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         guard++;
         if (guard > 200) begin
            check_val("in_ready_timeout", 0, 1);
            break;
         end
      end
      sb_q.push_back(e);
      if (last != 0) lasts_sent++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0 && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (sb_q.size() != 0) check_val("drain_timeout", sb_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_px(input int mode, input int thr, input int last, input bit use_exp,
                          input int ep, input int ee);
      send(pack_px(), mode, thr, last, use_exp, ep, ee);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         cnt_q.delete();
         model_cnt = 0;
      end else begin
         if (count_valid) begin
            cv_pulses++;
            if (cnt_q.size() == 0) check_val("count_unexpected", 1, 0);
            else check_val("edge_count", edge_count, cnt_q.pop_front());
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               check_val("out_unexpected", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check_val("out_pix", bus.out_pix, mon_e.pix);
               check_val("out_edge", bus.out_edge, mon_e.edge_bit);
               check_val("out_last", bus.out_last, mon_e.last);
               $display("out pix=%0d edge=%0d last=%0d", bus.out_pix, bus.out_edge, bus.out_last);
               model_cnt += mon_e.edge_bit;
               if (mon_e.last != 0) begin
                  cnt_q.push_back(model_cnt);
                  model_cnt = 0;
               end
            end
         end
      end
   end

   initial begin
      int lat;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_win    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      cfg_mode      = 2'd0;
      cfg_thresh    = MAG_W'(60);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_out_pix", bus.out_pix, 0);
      check_val("rst_edge_count", edge_count, 0);
      check_val("rst_count_valid", count_valid, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Vertical edge, unstalled latency.
      px = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      send_px(0, 60, 0, 1, 255, 1);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val("latency", lat, 4);
      drain();

      send_px(2, 60, 0, 1, 255, 1);
      px = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
      for (int m = 0; m < 4; m++) send_px(m, 60, 0, 1, 0, 0);
      px = '{0, 0, 10, 0, 0, 0, 0, 0, 0};
      send_px(1, 60, 0, 1, 20, 0);
      send_px(2, 60, 0, 1, 0, 0);
      send_px(3, 60, 0, 1, 10, 0);
      send_px(2, 20, 0, 1, 255, 1);
      px = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
      send_px(2, 0, 1, 1, 255, 1);
      drain();

      // Eight-window stream with a 3-cycle downstream stall mid-stream.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               for (int k = 0; k < 9; k++) px[k] = int'($urandom_range(0, 255));
               send_px(i % 4, int'($urandom_range(0, 600)), (i == 7) ? 1 : 0, 0, 0, 0);
            end
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            held_pix = bus.out_pix;
            repeat (3) begin
               @(negedge clk);
               check_val("stall_in_ready", bus.in_ready, 0);
               check_val("stall_out_valid", bus.out_valid, 1);
               check_val("stall_out_pix", bus.out_pix, held_pix);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // 10-pixel frame with edges on pixels 2, 5, 9; then a 4-pixel frame with one edge.
      for (int i = 0; i < 10; i++) begin
         if (i == 1 || i == 4 || i == 8) px = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
         else px = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
         send_px(1, 60, (i == 9) ? 1 : 0, 0, 0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 2) px = '{0, 0, 10, 0, 0, 0, 0, 0, 0};
         else px = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
         send_px(0, 20, (i == 3) ? 1 : 0, 0, 0, 0);
      end
      px = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      send_px(0, 60, 1, 0, 0, 0);
      drain();

      // Partial frame plus in-flight pixels discarded by reset.
      px = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
      send_px(0, 60, 0, 0, 0, 0);
      send_px(0, 60, 0, 0, 0, 0);
      drain();
      for (int i = 0; i < 3; i++) send_px(0, 60, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_mid_out_valid", bus.out_valid, 0);
      check_val("rst_mid_edge_count", edge_count, 0);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_val("rst_mid_idle", bus.out_valid, 0);
      send_px(0, 60, 0, 0, 0, 0);
      px = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
      send_px(0, 60, 1, 0, 0, 0);
      drain();

      check_val("sb_empty", sb_q.size(), 0);
      check_val("cnt_q_empty", cnt_q.size(), 0);
      check_val("count_pulses", cv_pulses, lasts_sent - 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
